// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: operation bit indices, widths and
// the divide-by-zero quotient pattern.
package alu_pkg;

  localparam int unsigned BITS      = 32;
  localparam int unsigned SIG_COUNT = 12;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_SHR = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_ROR = 6;
  localparam int unsigned OP_ROL = 7;
  localparam int unsigned OP_AND = 8;
  localparam int unsigned OP_OR  = 9;
  localparam int unsigned OP_NEG = 10;
  localparam int unsigned OP_NOT = 11;

  localparam logic [BITS-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed divider: quotient truncates toward zero, remainder
// follows the dividend's sign; zero divisor and -2^31/-1 handled explicitly.
module alu_divider #(
  parameter int unsigned BITS = 32
) (
  input  logic signed [BITS-1:0] num,
  input  logic signed [BITS-1:0] den,
  output logic signed [BITS-1:0] quot,
  output logic signed [BITS-1:0] rem
);
  import alu_pkg::*;

  logic [BITS-1:0] int_min;

  always_comb begin
    int_min = '0;
    int_min[BITS-1] = 1'b1;
    quot = '0;
    rem  = '0;
    if (den == '0) begin
      quot = DIV_ZERO_QUOT;
      rem  = num;
    end else if ((num == int_min) && (den == '1)) begin
      quot = int_min;
      rem  = '0;
    end else begin
      quot = num / den;
      rem  = num % den;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered 32-bit ALU: one-hot control selects an operation, result is
// captured into the HI/LO pair on the rising edge of clk.
module alu_core #(
  parameter int unsigned BITS      = alu_pkg::BITS,
  parameter int unsigned SIG_COUNT = alu_pkg::SIG_COUNT
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic        [SIG_COUNT-1:0] ctrl_signal,
  input  logic signed [BITS-1:0]      X,
  input  logic signed [BITS-1:0]      Y,
  output logic signed [BITS-1:0]      OpResult_HI,
  output logic signed [BITS-1:0]      OpResult_LO
);
  import alu_pkg::*;

  localparam int unsigned SHW = $clog2(BITS);

  logic [SHW-1:0]           amt;
  logic [2*BITS-1:0]        dbl;
  logic [2*BITS-1:0]        ror_full;
  logic [2*BITS-1:0]        rol_full;
  logic signed [2*BITS-1:0] prod;
  logic signed [BITS-1:0]   quot;
  logic signed [BITS-1:0]   rem;
  logic [BITS-1:0]          next_hi;
  logic [BITS-1:0]          next_lo;

  alu_divider #(.BITS(BITS)) u_div (
    .num  (X),
    .den  (Y),
    .quot (quot),
    .rem  (rem)
  );

  // Rotates shift a doubled copy of X so a zero amount needs no special case.
  always_comb begin
    amt      = Y[SHW-1:0];
    dbl      = {X, X};
    ror_full = dbl >> amt;
    rol_full = dbl << amt;
    prod     = X * Y;
  end

  // if/else chain gives lowest-index priority when several bits are set.
  always_comb begin
    next_hi = '0;
    next_lo = '0;
    if      (ctrl_signal[OP_ADD]) next_lo = X + Y;
    else if (ctrl_signal[OP_SUB]) next_lo = X - Y;
    else if (ctrl_signal[OP_MUL]) {next_hi, next_lo} = prod;
    else if (ctrl_signal[OP_DIV]) begin
      next_hi = rem;
      next_lo = quot;
    end
    else if (ctrl_signal[OP_SHR]) next_lo = X >> amt;
    else if (ctrl_signal[OP_SHL]) next_lo = X << amt;
    else if (ctrl_signal[OP_ROR]) next_lo = ror_full[BITS-1:0];
    else if (ctrl_signal[OP_ROL]) next_lo = rol_full[2*BITS-1:BITS];
    else if (ctrl_signal[OP_AND]) next_lo = X & Y;
    else if (ctrl_signal[OP_OR])  next_lo = X | Y;
    else if (ctrl_signal[OP_NEG]) next_lo = -X;
    else if (ctrl_signal[OP_NOT]) next_lo = ~X;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      OpResult_HI <= '0;
      OpResult_LO <= '0;
    end else begin
      OpResult_HI <= next_hi;
      OpResult_LO <= next_lo;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core with hand-computed expectations.
module tb_alu_core;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [11:0] ctrl;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_core #(.BITS(32), .SIG_COUNT(12)) dut (
    .clk         (clk),
    .clr         (clr),
    .ctrl_signal (ctrl),
    .X           (x),
    .Y           (y),
    .OpResult_HI (hi),
    .OpResult_LO (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [11:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    ctrl = c;
    x    = a;
    y    = b;
    @(posedge clk);
    #1;
    check({tag, " HI"}, hi, ehi);
    check({tag, " LO"}, lo, elo);
  endtask

  function automatic logic [11:0] op(input int unsigned idx);
    logic [11:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  localparam logic [31:0] P15 = 32'd15;
  localparam logic [31:0] M15 = 32'hFFFF_FFF1;
  localparam logic [31:0] P5  = 32'd5;
  localparam logic [31:0] M5  = 32'hFFFF_FFFB;

  initial begin
    clr  = 1'b0;
    ctrl = op(OP_ADD);
    x    = P15;
    y    = P5;
    repeat (2) @(posedge clk);
    #1;
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("release HI", hi, 32'd0);
    check("release LO", lo, 32'd20);

    do_op("add ++", op(OP_ADD), P15, P5, 32'd0, 32'd20);
    do_op("add -+", op(OP_ADD), M15, P5, 32'd0, 32'hFFFF_FFF6);
    do_op("add +-", op(OP_ADD), P15, M5, 32'd0, 32'd10);
    do_op("add --", op(OP_ADD), M15, M5, 32'd0, 32'hFFFF_FFEC);
    do_op("sub ++", op(OP_SUB), P15, P5, 32'd0, 32'd10);
    do_op("sub -+", op(OP_SUB), M15, P5, 32'd0, 32'hFFFF_FFEC);
    do_op("sub +-", op(OP_SUB), P15, M5, 32'd0, 32'd20);
    do_op("sub --", op(OP_SUB), M15, M5, 32'd0, 32'hFFFF_FFF6);
    do_op("add wrap", op(OP_ADD), 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000);

    do_op("mul ++", op(OP_MUL), P15, P5, 32'd0, 32'd75);
    do_op("mul -+", op(OP_MUL), M15, P5, 32'hFFFF_FFFF, 32'hFFFF_FFB5);
    do_op("mul +-", op(OP_MUL), P15, M5, 32'hFFFF_FFFF, 32'hFFFF_FFB5);
    do_op("mul --", op(OP_MUL), M15, M5, 32'd0, 32'd75);
    do_op("mul -1*-1", op(OP_MUL), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
    do_op("mul big", op(OP_MUL), 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

    do_op("div ++", op(OP_DIV), P15, P5, 32'd0, 32'd3);
    do_op("div -+", op(OP_DIV), M15, P5, 32'd0, 32'hFFFF_FFFD);
    do_op("div +-", op(OP_DIV), P15, M5, 32'd0, 32'hFFFF_FFFD);
    do_op("div --", op(OP_DIV), M15, M5, 32'd0, 32'd3);
    do_op("div 17/-5", op(OP_DIV), 32'd17, M5, 32'd2, 32'hFFFF_FFFD);
    do_op("div -17/5", op(OP_DIV), 32'hFFFF_FFEF, P5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    do_op("div by 0", op(OP_DIV), 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    do_op("div ovf", op(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    do_op("shr", op(OP_SHR), 32'd16, 32'd2, 32'd0, 32'd4);
    do_op("shl", op(OP_SHL), 32'd16, 32'd2, 32'd0, 32'd64);
    do_op("ror", op(OP_ROR), 32'd16, 32'd2, 32'd0, 32'd4);
    do_op("rol", op(OP_ROL), 32'd16, 32'd2, 32'd0, 32'd64);
    do_op("ror wrap", op(OP_ROR), 32'd1, 32'd1, 32'd0, 32'h8000_0000);
    do_op("rol wrap", op(OP_ROL), 32'h8000_0000, 32'd1, 32'd0, 32'd1);
    do_op("shr 31", op(OP_SHR), 32'h8000_0000, 32'd31, 32'd0, 32'd1);
    do_op("shl hiY", op(OP_SHL), 32'd16, 32'h0000_0021, 32'd0, 32'd32);
    do_op("ror 0", op(OP_ROR), 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678);

    do_op("and", op(OP_AND), P15, 32'd0, 32'd0, 32'd0);
    do_op("or", op(OP_OR), P15, 32'd0, 32'd0, 32'd15);
    do_op("neg", op(OP_NEG), P15, 32'd0, 32'd0, 32'hFFFF_FFF1);
    do_op("not", op(OP_NOT), P15, 32'd0, 32'd0, 32'hFFFF_FFF0);
    do_op("and mix", op(OP_AND), 32'hF0F0_FFFF, 32'h0FF0_1234, 32'd0, 32'h00F0_1234);
    do_op("neg min", op(OP_NEG), 32'h8000_0000, 32'd99, 32'd0, 32'h8000_0000);

    do_op("ctrl zero", 12'h000, P15, P5, 32'd0, 32'd0);
    do_op("ctrl 0x003", 12'h003, P15, P5, 32'd0, 32'd20);
    do_op("ctrl 0x810", 12'h810, 32'd16, 32'd2, 32'd0, 32'd4);
    do_op("ctrl 0x00c", 12'h00C, M15, P5, 32'hFFFF_FFFF, 32'hFFFF_FFB5);

    // Outputs must hold between edges even as inputs change.
    do_op("b2b mul", op(OP_MUL), 32'd6, 32'd7, 32'd0, 32'd42);
    ctrl = op(OP_SUB);
    x    = 32'd1;
    y    = 32'd2;
    #2;
    check("hold LO", lo, 32'd42);
    @(posedge clk);
    #1;
    check("b2b sub LO", lo, 32'hFFFF_FFFF);
    check("b2b sub HI", hi, 32'd0);

    clr = 1'b0;
    #1;
    check("async clr LO", lo, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    do_op("after clr", op(OP_OR), 32'hA000_0000, 32'h0000_000B, 32'd0, 32'hA000_000B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Registered 32-bit integer ALU for the bus-architecture datapath. A 12-bit one-hot control word selects one of 12 operations on two signed 32-bit operands X and Y. The result is captured on the clock edge into a 64-bit HI/LO result pair, which feeds the Z/HI/LO registers on the internal bus. Multiply and divide use both halves; all other operations write LO only.

## Interface
- `BITS`, default 32: operand width.
- `SIG_COUNT`, default 12: control word width; one bit per operation.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-low reset.
- `ctrl_signal`  in  12  one-hot operation select.
- `X`  in  32  signed operand A.
- `Y`  in  32  signed operand B; shift/rotate amount.
- `OpResult_HI`  out  32  signed upper result (product high word or remainder).
- `OpResult_LO`  out  32  signed lower result (product low word, quotient or 32-bit result).

## Operation
Operation by control bit index:
- 0 ADD: LO = X+Y, wraps mod 2^32.
- 1 SUB: LO = X−Y, wraps mod 2^32.
- 2 MUL: {HI,LO} = 64-bit signed product X·Y.
- 3 DIV: LO = signed quotient, truncated toward zero; HI = remainder, which takes the dividend's sign.
- 4 SHR: logical right shift of X by Y[4:0].
- 5 SHL: left shift of X by Y[4:0].
- 6 ROR: rotate X right by Y[4:0].
- 7 ROL: rotate X left by Y[4:0].
- 8 AND: X & Y.
- 9 OR: X | Y.
- 10 NEG: LO = −X; Y is ignored; −(−2^31) = −2^31.
- 11 NOT: LO = ~X; Y is ignored.

Rules common to all operations:
- HI = 0 for every operation except MUL and DIV.
- Divide by zero (Y=0): LO = 0xFFFFFFFF, HI = X. No trap is raised.
- Overflow divide (−2^31 / −1): LO = 0x80000000, HI = 0.
- ctrl_signal all zero: next result is HI = LO = 0.
- More than one bit set: the lowest set index wins.
- Y[31:5] is ignored for shifts and rotates.

## Timing
- Reset: `clr`=0 asynchronously forces HI = LO = 0 and holds them there while low.
- Latency: the result computed from the inputs sampled at a rising edge appears at `OpResult_HI`/`OpResult_LO` immediately after that edge. All operations, including MUL and DIV, have 1-cycle latency.
- Combinational path: MUL and DIV must close timing within one cycle.
- No handshake: a new operation may be issued every cycle. Outputs hold their value until the next edge.
- Reset deasserted mid-stream: the first edge after release captures the current inputs normally.

## Structure
- Shared package `alu_pkg` holds:
  - localparams for the 12 operation bit indices (`OP_ADD`=0 … `OP_NOT`=11);
  - the constants `BITS` and `SIG_COUNT`;
  - the divide-by-zero quotient constant.
- Sub-module `alu_divider`: combinational signed 32/32 divider producing quotient and remainder. It handles the zero-divisor and overflow cases internally.
- The remaining operations sit in one case/priority block driving a 64-bit next-result register.

## Test plan
- Reset: hold `clr`=0 with ctrl=ADD, X=15, Y=5 → HI = LO = 0. Release → after the next edge LO = 20, HI = 0.
- ADD/SUB with all four sign combinations of (±15, ±5):
  - ADD: 20, −10, 10, −20.
  - SUB: 10, −20, 20, −10.
  - HI = 0 in every case.
- MUL and DIV with (±15, ±5):
  - MUL (15,5) → {HI,LO} = 75.
  - MUL (−15,5) → HI = 0xFFFFFFFF, LO = 0xFFFFFFB5.
  - MUL (−15,−5) → 75.
  - DIV (15,5) → LO = 3.
  - DIV (−15,5) → LO = −3.
  - DIV (15,−5) → LO = −3.
  - DIV (−15,−5) → LO = 3.
  - HI = 0 for every DIV case.
  - DIV (17,−5) → LO = −3, HI = 2.
  - DIV (7,0) → LO = 0xFFFFFFFF, HI = 7.
- Shifts/rotates with X=16, Y=2:
  - SHR → 4; SHL → 64; ROR → 4; ROL → 64.
  - ROR with X=1, Y=1 → 0x80000000.
  - SHR with X=0x80000000, Y=31 → 1.
- Logic/unary with X=15, Y=0:
  - AND → 0; OR → 15; NEG → 0xFFFFFFF1; NOT → 0xFFFFFFF0; HI = 0 throughout.
- Control edge cases:
  - ctrl = 0 → HI = LO = 0.
  - ctrl = 0x003 with X=15, Y=5 → ADD wins, LO = 20.
  - Back-to-back ops on consecutive cycles each produce their own result one cycle later.
